// File: rtl/spi_master.sv
// Single-slave SPI master: one DATA_WIDTH-bit full-duplex frame per accepted start,
// configurable clock divider and SPI mode (CPOL/CPHA), all pin outputs registered.
module spi_master #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int SPI_FREQ   = 5_000_000,
  parameter int DATA_WIDTH = 8,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_send,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  csn,
  output logic                  mosi,
  output logic                  busy,
  output logic                  spi_done,
  output logic [DATA_WIDTH-1:0] data_recv
);

  localparam int   HALF     = CLK_FREQ / (2 * SPI_FREQ);
  localparam int   HW       = (HALF > 2) ? $clog2(HALF) : 1;
  localparam int   EDGES    = 2 * DATA_WIDTH;
  localparam int   EW       = $clog2(EDGES);
  localparam logic IDLE_LVL = (CPOL != 0);

  generate
    if (HALF < 2) begin : g_bad_half
      $error("spi_master: CLK_FREQ/(2*SPI_FREQ) must be at least 2");
    end
    if (DATA_WIDTH < 2) begin : g_bad_width
      $error("spi_master: DATA_WIDTH must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_HOLD,
    S_DONE
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [HW-1:0]         hcnt;
  logic [EW-1:0]         edge_cnt;
  logic [DATA_WIDTH-1:0] tx_sreg;
  logic [DATA_WIDTH-1:0] rx_sreg;
  logic                  sample_q;

  logic half_end;
  logic last_edge;
  logic enter_first;
  logic enter_next;
  logic next_odd;
  logic sample_now;
  logic shift_now;
  logic accept;

  logic csn_d;
  logic sclk_d;
  logic mosi_d;
  logic done_d;

  assign half_end  = (hcnt == HW'(HALF - 1));
  assign last_edge = (edge_cnt == EW'(EDGES - 1));
  assign accept    = (state == S_IDLE) && start;
  assign busy      = (state != S_IDLE);

  // Edge bookkeeping is expressed as "entering half-period n" of XFER; n = 0 is
  // entered from SETUP, every later n from the previous half-period.
  assign enter_first = (state == S_SETUP) && half_end;
  assign enter_next  = (state == S_XFER) && half_end && !last_edge;
  assign next_odd    = ~edge_cnt[0];

  generate
    if (CPHA == 0) begin : g_cpha0
      assign sample_now = enter_first || (enter_next && !next_odd);
      assign shift_now  = enter_next && next_odd && (edge_cnt != EW'(EDGES - 2));
    end else begin : g_cpha1
      assign sample_now = enter_next && next_odd;
      assign shift_now  = enter_next && !next_odd;
    end
  endgenerate

  // NOTE: every clocked process uses non-blocking assignments so all registers
  // update from the same pre-edge values regardless of process order.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start)                 next_state = S_SETUP;
      S_SETUP: if (half_end)              next_state = S_XFER;
      S_XFER:  if (half_end && last_edge) next_state = S_HOLD;
      S_HOLD:  if (half_end)              next_state = S_DONE;
      S_DONE:  if (half_end)              next_state = S_IDLE;
      default:                            next_state = S_IDLE;
    endcase
  end

  // NOTE: counters and shift registers are reset too, so an aborted frame
  // leaves no residue that could leak into the next one.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      hcnt     <= '0;
      edge_cnt <= '0;
      tx_sreg  <= '0;
      rx_sreg  <= '0;
      sample_q <= 1'b0;
    end else begin
      if (state == S_IDLE || half_end) hcnt <= '0;
      else                             hcnt <= hcnt + 1'b1;

      if (state != S_XFER)  edge_cnt <= '0;
      else if (half_end)    edge_cnt <= last_edge ? '0 : edge_cnt + 1'b1;

      if (accept)         tx_sreg <= data_send;
      else if (shift_now) tx_sreg <= tx_sreg << 1;

      // Sampling is delayed one cycle so it lands on the registered sclk edge.
      sample_q <= sample_now;
      if (accept)        rx_sreg <= '0;
      else if (sample_q) rx_sreg <= {rx_sreg[DATA_WIDTH-2:0], miso};
    end
  end

  // NOTE: each output gets a default before the case so no path infers a latch.
  always_comb begin
    csn_d  = 1'b1;
    sclk_d = IDLE_LVL;
    mosi_d = 1'b0;
    done_d = 1'b0;
    case (state)
      S_IDLE: begin
        csn_d = 1'b1;
      end
      S_SETUP: begin
        csn_d  = 1'b0;
        mosi_d = (CPHA == 0) ? tx_sreg[DATA_WIDTH-1] : 1'b0;
      end
      S_XFER: begin
        csn_d  = 1'b0;
        sclk_d = IDLE_LVL ^ ~edge_cnt[0];
        mosi_d = tx_sreg[DATA_WIDTH-1];
      end
      S_HOLD: begin
        csn_d  = 1'b0;
        mosi_d = tx_sreg[DATA_WIDTH-1];
      end
      S_DONE: begin
        csn_d  = 1'b1;
        done_d = (hcnt == '0);
      end
      default: begin
        csn_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      csn       <= 1'b1;
      sclk      <= IDLE_LVL;
      mosi      <= 1'b0;
      spi_done  <= 1'b0;
      data_recv <= '0;
    end else begin
      csn      <= csn_d;
      sclk     <= sclk_d;
      mosi     <= mosi_d;
      spi_done <= done_d;
      if (done_d) data_recv <= rx_sreg;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: mode-0 instance against a behavioural SPI slave, and a
// CPOL=1/CPHA=1 instance with mosi looped back to miso.
module tb_spi_master;

  localparam int HALF  = 50_000_000 / (2 * 5_000_000);
  localparam int DW    = 8;
  localparam int FRAME = HALF * (2 * DW + 2) + 1;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Mode-0 instance with slave model
  logic          start_a = 1'b0;
  logic [DW-1:0] data_a = '0;
  logic          miso_a;
  logic          sclk_a, csn_a, mosi_a, busy_a, spi_done_a;
  logic [DW-1:0] data_recv_a;

  spi_master dut_a (
    .clk(clk), .arstn(arstn), .start(start_a), .data_send(data_a), .miso(miso_a),
    .sclk(sclk_a), .csn(csn_a), .mosi(mosi_a), .busy(busy_a),
    .spi_done(spi_done_a), .data_recv(data_recv_a)
  );

  // Mode-3 instance, loopback
  logic          start_b = 1'b0;
  logic [DW-1:0] data_b = '0;
  logic          sclk_b, csn_b, mosi_b, busy_b, spi_done_b;
  logic [DW-1:0] data_recv_b;

  spi_master #(.CPOL(1), .CPHA(1)) dut_b (
    .clk(clk), .arstn(arstn), .start(start_b), .data_send(data_b), .miso(mosi_b),
    .sclk(sclk_b), .csn(csn_b), .mosi(mosi_b), .busy(busy_b),
    .spi_done(spi_done_b), .data_recv(data_recv_b)
  );

  // Mode-0 slave: presents MSB when selected, samples on rising sclk, shifts on falling.
  logic [DW-1:0] s_tx = '0;
  logic [DW-1:0] s_rx = '0;
  int            s_idx = 0;
  logic          ps_csn = 1'b1;
  logic          ps_sclk = 1'b0;

  assign miso_a = (s_idx < DW) ? s_tx[DW-1-s_idx] : 1'b0;

  always @(csn_a or sclk_a) begin
    if (csn_a !== ps_csn && csn_a === 1'b0) begin
      s_idx = 0;
      s_rx  = '0;
    end else if (csn_a === 1'b0 && sclk_a !== ps_sclk) begin
      if (sclk_a) s_rx = {s_rx[DW-2:0], mosi_a};
      else        s_idx++;
    end
    ps_csn  = csn_a;
    ps_sclk = sclk_a;
  end

  // Pin monitors, sampled on the falling clock edge
  int   done_a = 0, done_cyc_a = 0, csn_fall_a = 0, first_sclk_a = -1;
  int   edges_a = 0, rises_a = 0, last_rise_a = -1, bad_period_a = 0;
  int   hi_run_a = 0, last_gap_a = 0;
  logic p_csn_a = 1'b1, p_sclk_a = 1'b0;

  always @(negedge clk) begin
    if (spi_done_a) begin
      done_a++;
      done_cyc_a = cyc;
    end
    if (p_csn_a && !csn_a) begin
      csn_fall_a   = cyc;
      last_gap_a   = hi_run_a;
      hi_run_a     = 0;
      edges_a      = 0;
      rises_a      = 0;
      first_sclk_a = -1;
      last_rise_a  = -1;
      bad_period_a = 0;
    end
    if (csn_a) hi_run_a++;
    if (sclk_a !== p_sclk_a) begin
      edges_a++;
      if (first_sclk_a < 0) first_sclk_a = cyc;
      if (sclk_a) begin
        rises_a++;
        if (last_rise_a >= 0 && cyc - last_rise_a != 2 * HALF) bad_period_a++;
        last_rise_a = cyc;
      end
    end
    p_csn_a  = csn_a;
    p_sclk_a = sclk_a;
  end

  int   done_b = 0, low_b = 0;
  logic p_csn_b = 1'b1;

  always @(negedge clk) begin
    if (spi_done_b) done_b++;
    if (!csn_b) begin
      if (p_csn_b) low_b = 1;
      else         low_b++;
    end
    p_csn_b = csn_b;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    arstn   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (3) tick();
    checks++; if (csn_a !== 1'b1)      begin errors++; $display("FAIL reset_csn got %b want 1", csn_a); end
    checks++; if (sclk_a !== 1'b0)     begin errors++; $display("FAIL reset_sclk got %b want 0", sclk_a); end
    checks++; if (mosi_a !== 1'b0)     begin errors++; $display("FAIL reset_mosi got %b want 0", mosi_a); end
    checks++; if (busy_a !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
    checks++; if (spi_done_a !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", spi_done_a); end
    checks++; if (data_recv_a !== '0)  begin errors++; $display("FAIL reset_recv got %h want 00", data_recv_a); end
    checks++; if (sclk_b !== 1'b1)     begin errors++; $display("FAIL reset_sclk_cpol1 got %b want 1", sclk_b); end
    checks++; if (csn_b !== 1'b1)      begin errors++; $display("FAIL reset_csn_b got %b want 1", csn_b); end
    arstn = 1'b1;
    tick();
  endtask

  // One mode-0 frame; optionally pulses start with new data 20 cycles in.
  task automatic run_frame_a(input logic [DW-1:0] d, input logic [DW-1:0] w, input bit inject);
    int t0, base, seen_k;
    bit seen;
    s_tx    = w;
    base    = done_a;
    start_a = 1'b1;
    data_a  = d;
    tick();
    t0      = cyc;
    start_a = 1'b0;
    seen    = 1'b0;
    seen_k  = 0;
    for (int k = 0; k < 150; k++) begin
      if (inject && cyc - t0 == 20) begin
        start_a = 1'b1;
        data_a  = 8'hFF;
      end else begin
        start_a = 1'b0;
      end
      tick();
      if (!seen && done_a != base) begin
        seen   = 1'b1;
        seen_k = k;
        checks++; if (done_cyc_a - t0 != FRAME) begin errors++; $display("FAIL latency got %0d want %0d", done_cyc_a - t0, FRAME); end
        checks++; if (data_recv_a !== w)        begin errors++; $display("FAIL recv got %h want %h", data_recv_a, w); end
        checks++; if (s_rx !== d)               begin errors++; $display("FAIL slave_rx got %h want %h", s_rx, d); end
        checks++; if (rises_a != DW)            begin errors++; $display("FAIL sclk_rises got %0d want %0d", rises_a, DW); end
        checks++; if (bad_period_a != 0)        begin errors++; $display("FAIL sclk_period bad %0d want 0", bad_period_a); end
        checks++; if (csn_fall_a - t0 != 1)     begin errors++; $display("FAIL csn_fall got %0d want 1", csn_fall_a - t0); end
        checks++; if (first_sclk_a - t0 != 1 + HALF) begin errors++; $display("FAIL first_sclk got %0d want %0d", first_sclk_a - t0, 1 + HALF); end
      end else if (seen && k == seen_k + 1) begin
        checks++; if (spi_done_a !== 1'b0) begin errors++; $display("FAIL done_width got %b want 0", spi_done_a); end
      end
    end
    checks++; if (done_a - base != 1) begin errors++; $display("FAIL done_count got %0d want 1", done_a - base); end
  endtask

  task automatic run_frame_b(input logic [DW-1:0] d);
    int t0, base;
    bit seen;
    base    = done_b;
    start_b = 1'b1;
    data_b  = d;
    tick();
    t0      = cyc;
    start_b = 1'b0;
    seen    = 1'b0;
    for (int k = 0; k < 150; k++) begin
      tick();
      if (!seen && done_b != base) begin
        seen = 1'b1;
        checks++; if (cyc - t0 != FRAME)   begin errors++; $display("FAIL b_latency got %0d want %0d", cyc - t0, FRAME); end
        checks++; if (data_recv_b !== d)   begin errors++; $display("FAIL b_recv got %h want %h", data_recv_b, d); end
        checks++; if (low_b != FRAME - 1)  begin errors++; $display("FAIL b_csn_low got %0d want %0d", low_b, FRAME - 1); end
      end
    end
    checks++; if (done_b - base != 1) begin errors++; $display("FAIL b_done_count got %0d want 1", done_b - base); end
    checks++; if (sclk_b !== 1'b1)    begin errors++; $display("FAIL b_sclk_idle got %b want 1", sclk_b); end
  endtask

  task automatic test_mode0_random();
    run_frame_a(8'hA5, 8'h3C, 1'b0);
    for (int i = 0; i < 6; i++) run_frame_a(DW'($urandom), DW'($urandom), 1'b0);
  endtask

  task automatic test_ignore_start();
    run_frame_a(8'h3C, 8'h96, 1'b1);
  endtask

  task automatic test_mode3_loopback();
    run_frame_b(8'h81);
    for (int i = 0; i < 4; i++) run_frame_b(DW'($urandom));
  endtask

  task automatic test_mid_reset();
    int base;
    bit hit;
    s_tx    = 8'hC3;
    data_a  = 8'h77;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    hit     = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      tick();
      if (edges_a == 7) hit = 1'b1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL mid_reset_wait got no 7th edge want 7 edges"); end
    arstn = 1'b0;
    #1;
    checks++; if (csn_a !== 1'b1)      begin errors++; $display("FAIL mid_reset_csn got %b want 1", csn_a); end
    checks++; if (sclk_a !== 1'b0)     begin errors++; $display("FAIL mid_reset_sclk got %b want 0", sclk_a); end
    checks++; if (data_recv_a !== '0)  begin errors++; $display("FAIL mid_reset_recv got %h want 00", data_recv_a); end
    checks++; if (busy_a !== 1'b0)     begin errors++; $display("FAIL mid_reset_busy got %b want 0", busy_a); end
    base = done_a;
    tick();
    arstn = 1'b1;
    repeat (150) tick();
    checks++; if (done_a != base) begin errors++; $display("FAIL mid_reset_done got %0d want 0", done_a - base); end
    run_frame_a(8'h5A, DW'($urandom), 1'b0);
  endtask

  task automatic test_back_to_back();
    int base, falls, pf, pd;
    logic [DW-1:0] w;
    w       = DW'($urandom);
    s_tx    = w;
    data_a  = DW'($urandom);
    base    = done_a;
    pd      = done_a;
    pf      = csn_fall_a;
    falls   = 0;
    start_a = 1'b1;
    for (int k = 0; k < 400 && start_a; k++) begin
      tick();
      if (csn_fall_a != pf) begin
        pf = csn_fall_a;
        falls++;
        if (falls >= 2) begin
          checks++; if (last_gap_a < 5) begin errors++; $display("FAIL b2b_gap got %0d want >=5", last_gap_a); end
        end
      end
      if (done_a != pd) begin
        pd = done_a;
        checks++; if (data_recv_a !== w) begin errors++; $display("FAIL b2b_recv got %h want %h", data_recv_a, w); end
      end
      if (done_a - base == 3) start_a = 1'b0;
    end
    start_a = 1'b0;
    repeat (150) tick();
    checks++; if (done_a - base != 3) begin errors++; $display("FAIL b2b_done_count got %0d want 3", done_a - base); end
    checks++; if (falls != 3)         begin errors++; $display("FAIL b2b_frames got %0d want 3", falls); end
  endtask

  initial begin
    test_reset();
    test_mode0_random();
    test_ignore_start();
    test_mode3_loopback();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
